// File: rtl/sde_trigger_pkg.sv
// Shared defaults for the SDE trigger deconvolution datapath: widths and
// the coefficient values the block wakes up with.
package sde_trigger_pkg;

    localparam int DEF_N_CHAN   = 3;
    localparam int DEF_ADC_W    = 12;
    localparam int DEF_BL_EXTRA = 3;
    localparam int DEF_FD_W     = 6;
    localparam int DEF_FN_W     = 6;
    localparam int DEF_FN_FRAC  = 4;
    localparam int DEF_CNT_W    = 16;

    // Reset coefficients: no decay and unity normaliser.
    localparam int FD_RST_VAL = 0;

    function automatic int fn_unity(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/deconvolve_chan.sv
// One deconvolution channel: baseline floor, decay removal, clamp,
// normalise with half-up rounding, saturate; raw bypass rides alongside.
module deconvolve_chan
    import sde_trigger_pkg::*;
#(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int BL_EXTRA = DEF_BL_EXTRA,
    parameter int FD_W     = DEF_FD_W,
    parameter int FN_W     = DEF_FN_W,
    parameter int FN_FRAC  = DEF_FN_FRAC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [ADC_W-1:0]          adc_in,
    input  logic [ADC_W+BL_EXTRA-1:0] baseline,
    input  logic                      bypass,
    input  logic [FD_W-1:0]           fd,
    input  logic [FN_W-1:0]           fn,
    input  logic                      sat_clr,
    output logic [ADC_W-1:0]          adc_out,
    output logic [CNT_W-1:0]          sat_cnt
);

    localparam int B_W = ADC_W + FD_W + 1;
    localparam int C_W = ADC_W + FD_W;
    localparam int D_W = C_W + FN_W + 1;
    localparam int SH  = FD_W + FN_FRAC;
    localparam logic [D_W-1:0]   HALF    = D_W'(1) << (SH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADC_W-1:0]           bl_int, lvl, l_cur, l_prev, res;
    logic [C_W-1:0]             l_sh, fd_prod, c_next, c_q;
    logic signed [B_W-1:0]      b_next, b_q;
    logic [D_W-1:0]             d_next, d_q;
    logic                       sat;
    logic [3:0][ADC_W-1:0]      raw_q;
    logic [3:0]                 byp_q;
    logic                       bl_frac_unused;

    assign bl_int         = baseline[ADC_W+BL_EXTRA-1:BL_EXTRA];
    assign bl_frac_unused = ^baseline[BL_EXTRA-1:0];
    assign lvl            = (adc_in > bl_int) ? adc_in : bl_int;

    assign l_sh    = {l_cur, {FD_W{1'b0}}};
    assign fd_prod = C_W'(fd) * C_W'(l_prev);
    assign b_next  = $signed({1'b0, l_sh}) - $signed({1'b0, fd_prod});
    assign c_next  = b_q[B_W-1] ? '0 : b_q[C_W-1:0];
    assign d_next  = D_W'(c_q) * D_W'(fn) + HALF;

    // Anything above the output field means the result cannot be represented.
    assign sat = |d_q[D_W-1:SH+ADC_W];
    assign res = byp_q[3] ? raw_q[3] : (sat ? '1 : d_q[SH+ADC_W-1:SH]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            l_cur   <= '0;
            l_prev  <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            adc_out <= '0;
            raw_q   <= '0;
            byp_q   <= '0;
        end else if (EN) begin
            l_cur   <= lvl;
            l_prev  <= l_cur;
            b_q     <= b_next;
            c_q     <= c_next;
            d_q     <= d_next;
            adc_out <= res;
            raw_q   <= {raw_q[2:0], adc_in};
            byp_q   <= {byp_q[2:0], bypass};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sat_cnt <= '0;
        end else if (EN && sat && !byp_q[3]) begin
            if (sat_clr) begin
                sat_cnt <= CNT_W'(1);
            end else if (sat_cnt != CNT_MAX) begin
                sat_cnt <= sat_cnt + CNT_W'(1);
            end
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end
    end

endmodule

// File: rtl/deconvolve_multi.sv
// Multi-channel deconvolver: shared coefficient staging/commit, priming
// and OUT_VALID, around N_CHAN independent channel datapaths.
module deconvolve_multi
    import sde_trigger_pkg::*;
#(
    parameter int N_CHAN   = DEF_N_CHAN,
    parameter int ADC_W    = DEF_ADC_W,
    parameter int BL_EXTRA = DEF_BL_EXTRA,
    parameter int FD_W     = DEF_FD_W,
    parameter int FN_W     = DEF_FN_W,
    parameter int FN_FRAC  = DEF_FN_FRAC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               EN,
    input  logic [N_CHAN*ADC_W-1:0]            ADC_IN,
    input  logic [N_CHAN*(ADC_W+BL_EXTRA)-1:0] BASELINE,
    input  logic [FD_W-1:0]                    FD_IN,
    input  logic [FN_W-1:0]                    FN_IN,
    input  logic                               COEF_LOAD,
    input  logic [N_CHAN-1:0]                  BYPASS,
    input  logic                               SAT_CLR,
    output logic [N_CHAN*ADC_W-1:0]            ADC_OUT,
    output logic                               OUT_VALID,
    output logic [N_CHAN*CNT_W-1:0]            SAT_CNT
);

    localparam int BL_W = ADC_W + BL_EXTRA;
    localparam logic [FD_W-1:0] FD_RST     = FD_W'(FD_RST_VAL);
    localparam logic [FN_W-1:0] FN_RST     = FN_W'(fn_unity(FN_FRAC));
    localparam logic [2:0]      PRIME_DONE = 3'd4;

    logic [FD_W-1:0] shd_fd, act_fd, use_fd;
    logic [FN_W-1:0] shd_fn, act_fn, use_fn;
    logic            pending, commit;
    logic [2:0]      prime_cnt;

    // The committing strobe already computes with the new set, so a load
    // that coincides with a strobe takes effect exactly one strobe later.
    assign commit = EN && pending;
    assign use_fd = commit ? shd_fd : act_fd;
    assign use_fn = commit ? shd_fn : act_fn;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shd_fd    <= FD_RST;
            act_fd    <= FD_RST;
            shd_fn    <= FN_RST;
            act_fn    <= FN_RST;
            pending   <= 1'b0;
            prime_cnt <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            if (COEF_LOAD) begin
                shd_fd <= FD_IN;
                shd_fn <= FN_IN;
            end
            if (commit) begin
                act_fd <= shd_fd;
                act_fn <= shd_fn;
            end
            if (COEF_LOAD) begin
                pending <= 1'b1;
            end else if (EN) begin
                pending <= 1'b0;
            end
            if (EN && prime_cnt != PRIME_DONE) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
            OUT_VALID <= EN && (prime_cnt == PRIME_DONE);
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        deconvolve_chan #(
            .ADC_W    (ADC_W),
            .BL_EXTRA (BL_EXTRA),
            .FD_W     (FD_W),
            .FN_W     (FN_W),
            .FN_FRAC  (FN_FRAC),
            .CNT_W    (CNT_W)
        ) u_chan (
            .CLK      (CLK),
            .RST      (RST),
            .EN       (EN),
            .adc_in   (ADC_IN[c*ADC_W +: ADC_W]),
            .baseline (BASELINE[c*BL_W +: BL_W]),
            .bypass   (BYPASS[c]),
            .fd       (use_fd),
            .fn       (use_fn),
            .sat_clr  (SAT_CLR),
            .adc_out  (ADC_OUT[c*ADC_W +: ADC_W]),
            .sat_cnt  (SAT_CNT[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_deconvolve_multi.sv
// Self-checking bench for deconvolve_multi: directed table, hand-written
// corner sequences and random traffic against a strobe-history model.
module tb_deconvolve_multi;

    localparam int N_CHAN   = 3;
    localparam int ADC_W    = 12;
    localparam int BL_EXTRA = 3;
    localparam int FD_W     = 6;
    localparam int FN_W     = 6;
    localparam int FN_FRAC  = 4;
    localparam int CNT_W    = 16;
    localparam int BL_W     = ADC_W + BL_EXTRA;
    localparam int OUT_MAX  = (1 << ADC_W) - 1;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int HIST     = 4096;

    logic                      CLK = 1'b0;
    logic                      RST;
    logic                      EN;
    logic [N_CHAN*ADC_W-1:0]   ADC_IN;
    logic [N_CHAN*BL_W-1:0]    BASELINE;
    logic [FD_W-1:0]           FD_IN;
    logic [FN_W-1:0]           FN_IN;
    logic                      COEF_LOAD;
    logic [N_CHAN-1:0]         BYPASS;
    logic                      SAT_CLR;
    logic [N_CHAN*ADC_W-1:0]   ADC_OUT;
    logic                      OUT_VALID;
    logic [N_CHAN*CNT_W-1:0]   SAT_CNT;

    deconvolve_multi dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .ADC_IN    (ADC_IN),
        .BASELINE  (BASELINE),
        .FD_IN     (FD_IN),
        .FN_IN     (FN_IN),
        .COEF_LOAD (COEF_LOAD),
        .BYPASS    (BYPASS),
        .SAT_CLR   (SAT_CLR),
        .ADC_OUT   (ADC_OUT),
        .OUT_VALID (OUT_VALID),
        .SAT_CNT   (SAT_CNT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: every accepted strobe is logged with its level, raw sample and
    // the coefficient set in force; outputs are computed from that history.
    int m_n;
    int m_fd_act, m_fn_act, m_fd_shd, m_fn_shd;
    bit m_pend, m_valid;
    int m_out [N_CHAN];
    int m_cnt [N_CHAN];
    int h_l   [N_CHAN][HIST];
    int h_raw [N_CHAN][HIST];
    bit h_byp [N_CHAN][HIST];
    int h_fd  [HIST];
    int h_fn  [HIST];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int s, b, d, q, adc, bl;
        bit ev;
        if (RST) begin
            m_n = 0; m_pend = 0; m_valid = 0;
            m_fd_act = 0; m_fd_shd = 0;
            m_fn_act = 1 << FN_FRAC; m_fn_shd = 1 << FN_FRAC;
            for (int c = 0; c < N_CHAN; c++) begin
                m_out[c] = 0; m_cnt[c] = 0; h_l[c][0] = 0;
            end
            return;
        end
        m_valid = 0;
        if (EN) begin
            if (m_pend) begin
                m_fd_act = m_fd_shd; m_fn_act = m_fn_shd; m_pend = 0;
            end
            m_n++;
            h_fd[m_n] = m_fd_act;
            h_fn[m_n] = m_fn_act;
            for (int c = 0; c < N_CHAN; c++) begin
                adc = int'(ADC_IN[c*ADC_W +: ADC_W]);
                bl  = int'(BASELINE[c*BL_W +: BL_W]) >> BL_EXTRA;
                h_l[c][m_n]   = (adc > bl) ? adc : bl;
                h_raw[c][m_n] = adc;
                h_byp[c][m_n] = BYPASS[c];
            end
            m_valid = (m_n >= 5);
        end
        if (COEF_LOAD) begin
            m_fd_shd = int'(FD_IN); m_fn_shd = int'(FN_IN); m_pend = 1;
        end
        for (int c = 0; c < N_CHAN; c++) begin
            ev = 0;
            if (EN && m_n >= 5) begin
                s = m_n - 4;
                b = h_l[c][s] * (1 << FD_W) - h_fd[s+1] * h_l[c][s-1];
                if (b < 0) b = 0;
                d = b * h_fn[m_n-1] + (1 << (FD_W + FN_FRAC - 1));
                q = d >> (FD_W + FN_FRAC);
                ev = (q > OUT_MAX) && !h_byp[c][s];
                if (h_byp[c][s]) m_out[c] = h_raw[c][s];
                else             m_out[c] = (q > OUT_MAX) ? OUT_MAX : q;
            end
            if (ev)           m_cnt[c] = SAT_CLR ? 1 : ((m_cnt[c] == CNT_MAX) ? CNT_MAX : m_cnt[c] + 1);
            else if (SAT_CLR) m_cnt[c] = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        model_cycle();
        check("valid", OUT_VALID, m_valid);
        for (int c = 0; c < N_CHAN; c++) begin
            check("adc_out", ADC_OUT[c*ADC_W +: ADC_W], m_out[c]);
            check("sat_cnt", SAT_CNT[c*CNT_W +: CNT_W], m_cnt[c]);
        end
    endtask

    task automatic set_all(input int adc, input int bl, input bit byp);
        for (int c = 0; c < N_CHAN; c++) begin
            ADC_IN[c*ADC_W +: ADC_W] = ADC_W'(adc);
            BASELINE[c*BL_W +: BL_W] = BL_W'(bl);
            BYPASS[c]                = byp;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; COEF_LOAD = 1'b0; SAT_CLR = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic load_coef(input int fd, input int fn, input bit with_en);
        FD_IN = FD_W'(fd); FN_IN = FN_W'(fn); COEF_LOAD = 1'b1; EN = with_en;
        tick();
        COEF_LOAD = 1'b0;
    endtask

    task automatic check_all_out(input string name, input int exp);
        for (int c = 0; c < N_CHAN; c++) check(name, ADC_OUT[c*ADC_W +: ADC_W], exp);
    endtask

    typedef struct {
        int fd;
        int fn;
        int bl;
        int adc;
        bit byp;
        int exp_out;
        int exp_sat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        RST = 1'b1; EN = 1'b0; COEF_LOAD = 1'b0; SAT_CLR = 1'b0;
        FD_IN = '0; FN_IN = '0; BYPASS = '0; ADC_IN = '0; BASELINE = '0;

        //          fd  fn   bl   adc  byp  out  sat
        tbl[0]  = '{ 0, 16,   0,  100, 0,   100, 0};
        tbl[1]  = '{32, 32,   0,  200, 0,   200, 0};
        tbl[2]  = '{ 0, 16, 640,   50, 0,    80, 0};
        tbl[3]  = '{ 0, 48,   0, 4095, 0,  4095, 3};
        tbl[4]  = '{ 0, 48,   0, 4095, 1,  4095, 0};
        tbl[5]  = '{16, 16,   0, 1000, 0,   750, 0};
        tbl[6]  = '{ 0, 24,   0,    3, 0,     5, 0};
        tbl[7]  = '{63, 16,   0,   64, 0,     1, 0};
        tbl[8]  = '{ 0, 16, 643,   50, 0,    80, 0};
        tbl[9]  = '{ 0, 16,   0, 4095, 0,  4095, 0};
        tbl[10] = '{ 0, 17,   0, 4095, 0,  4095, 3};
        tbl[11] = '{ 0, 16, 800,   30, 1,    30, 0};

        do_reset();
        check_all_out("rst_out", 0);
        check("rst_valid", OUT_VALID, 0);
        check("rst_sat", SAT_CNT, 0);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            load_coef(tbl[i].fd, tbl[i].fn, 1'b0);
            set_all(tbl[i].adc, tbl[i].bl, tbl[i].byp);
            EN = 1'b1;
            repeat (7) tick();
            check_all_out($sformatf("tbl%0d_out", i), tbl[i].exp_out);
            for (int c = 0; c < N_CHAN; c++)
                check($sformatf("tbl%0d_sat", i), SAT_CNT[c*CNT_W +: CNT_W], tbl[i].exp_sat);
            check($sformatf("tbl%0d_valid", i), OUT_VALID, 1);
        end

        // Step 0 -> 200 with FD=0.5, FN=2.0.
        do_reset();
        load_coef(32, 32, 1'b0);
        set_all(0, 0, 1'b0);
        EN = 1'b1;
        repeat (5) tick();
        set_all(200, 0, 1'b0);
        repeat (4) tick();
        check_all_out("step_pre", 0);
        tick(); check_all_out("step_0", 400);
        tick(); check_all_out("step_1", 200);
        tick(); check_all_out("step_2", 200);

        // Load coincident with a strobe: old set on that strobe, new one after.
        do_reset();
        set_all(100, 0, 1'b0);
        EN = 1'b1;
        repeat (6) tick();
        load_coef(0, 32, 1'b1);
        check_all_out("coef_j", 100);
        EN = 1'b0;
        repeat (2) tick();
        check_all_out("coef_hold", 100);
        check("coef_hold_valid", OUT_VALID, 0);
        EN = 1'b1;
        tick(); check_all_out("coef_j1", 100);
        tick(); check_all_out("coef_j2", 200);

        // Asynchronous reset mid-stream, then re-priming.
        set_all(100, 0, 1'b0);
        repeat (3) tick();
        #2 RST = 1'b1;
        #1;
        check_all_out("async_rst_out", 0);
        check("async_rst_valid", OUT_VALID, 0);
        EN = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reprime_valid", OUT_VALID, 0);
        end
        tick();
        check("reprime_valid5", OUT_VALID, 1);
        check_all_out("reprime_out", 100);

        // Saturation clear coincident with an event restarts the count at 1.
        do_reset();
        load_coef(0, 48, 1'b0);
        set_all(4095, 0, 1'b0);
        EN = 1'b1;
        repeat (7) tick();
        SAT_CLR = 1'b1;
        tick();
        SAT_CLR = 1'b0;
        for (int c = 0; c < N_CHAN; c++) check("clr_coincide", SAT_CNT[c*CNT_W +: CNT_W], 1);

        // Random traffic, checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            EN        = ($urandom_range(0, 9) < 7);
            COEF_LOAD = ($urandom_range(0, 19) == 0);
            FD_IN     = FD_W'($urandom_range(0, 63));
            FN_IN     = FN_W'($urandom_range(0, 63));
            SAT_CLR   = ($urandom_range(0, 29) == 0);
            RST       = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < N_CHAN; c++) begin
                if ($urandom_range(0, 1) == 1) ADC_IN[c*ADC_W +: ADC_W] = ADC_W'($urandom_range(3000, 4095));
                else                           ADC_IN[c*ADC_W +: ADC_W] = ADC_W'($urandom_range(0, 4095));
                BASELINE[c*BL_W +: BL_W] = BL_W'($urandom_range(0, 8000));
                BYPASS[c] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        RST = 1'b0; COEF_LOAD = 1'b0; SAT_CLR = 1'b0; EN = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/deconvolve_multi.md
DECONVOLVE_MULTI -- requirements
Module: deconvolve_multi

Interface
REQ-001 Parameter N_CHAN, default 3: number of independent deconvolution channels.
REQ-002 Parameter ADC_W, default 12: ADC sample width.
REQ-003 Parameter BL_EXTRA, default 3: fractional baseline bits.
REQ-004 Parameter FD_W, default 6: decay constant width, pure fraction .ffffff.
REQ-005 Parameters FN_W, default 6, and FN_FRAC, default 4: normaliser width and its fractional bits.
REQ-006 Parameter CNT_W, default 16: saturation counter width.
REQ-007 CLK  in  1  single clock for the whole block; one clock, no other clock domains.
REQ-008 RST  in  1  reset, asynchronous, active-high.
REQ-009 EN  in  1  sample strobe; all pipeline stages advance only on cycles with EN=1.
REQ-010 ADC_IN  in  N_CHAN*ADC_W  filtered ADC samples; channel c occupies bits [c*ADC_W +: ADC_W].
REQ-011 BASELINE  in  N_CHAN*(ADC_W+BL_EXTRA)  per-channel baseline with BL_EXTRA fractional bits.
REQ-012 FD_IN  in  FD_W  staged decay constant.
REQ-013 FN_IN  in  FN_W  staged normaliser.
REQ-014 COEF_LOAD  in  1  one-cycle pulse that captures FD_IN and FN_IN into the shadow registers.
REQ-015 BYPASS  in  N_CHAN  per-channel pass-through select.
REQ-016 SAT_CLR  in  1  clears all saturation counters.
REQ-017 ADC_OUT  out  N_CHAN*ADC_W  deconvolved samples.
REQ-018 OUT_VALID  out  1  one-cycle pulse marking a new ADC_OUT word.
REQ-019 SAT_CNT  out  N_CHAN*CNT_W  per-channel count of output saturations.

Function
REQ-020 Stage 1 SHALL compute L_k = max(ADC_IN, integer part of BASELINE) and hold L_{k-1}.
REQ-021 Stage 2 SHALL compute the signed value B = L_k*2^FD_W - FD*L_{k-1}, ADC_W+FD_W+1 bits wide.
REQ-022 Stage 3 SHALL clamp negative B to 0.
REQ-023 Stage 4 SHALL compute D = C*FN + 2^(FD_W+FN_FRAC-1), so the result is rounded half-up at the output LSB.
REQ-024 Stage 5 SHALL output D >> (FD_W+FN_FRAC) and saturate to 2^ADC_W-1 when any bit above the output field is set.
REQ-025 Latency SHALL be 5 EN strobes: a sample taken on EN strobe k appears on ADC_OUT in the cycle after EN strobe k+4.
REQ-026 OUT_VALID SHALL pulse on the cycle after each EN strobe once 5 EN strobes have been seen since reset, and SHALL stay 0 otherwise.
REQ-027 With EN=0, all pipeline registers, ADC_OUT and the active coefficients SHALL hold their values.
REQ-028 A channel with BYPASS=1 SHALL output raw ADC_IN through the same 5-strobe latency; the BYPASS value is sampled at stage 1 and travels with the data.
REQ-029 On COEF_LOAD, FD_IN and FN_IN SHALL be latched into the shadow registers.
REQ-030 The shadow values SHALL be copied to the active coefficients on the first EN strobe strictly after the load, and all channels switch on the same strobe.
REQ-031 If COEF_LOAD and EN coincide, that EN strobe SHALL use the old active coefficients, and the new values apply from the next EN strobe.
REQ-032 A second COEF_LOAD before the commit SHALL overwrite the shadow values; the last load wins.
REQ-033 SAT_CNT[c] SHALL increment on each stage-5 saturation of channel c that is not bypassed, and SHALL hold at 2^CNT_W-1 without wrapping.
REQ-034 If SAT_CLR and a saturation event coincide, the counter SHALL become 1.

Reset
REQ-035 On RST, all pipeline registers, ADC_OUT, OUT_VALID, SAT_CNT and the primed-count SHALL go to 0.
REQ-036 On RST, the shadow and active FD SHALL go to 0 and the shadow and active FN SHALL go to 1.0 (2^FN_FRAC), giving unity gain with no decay.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight samples and restart priming.

Structure
REQ-038 Default widths and the reset coefficient constants SHALL live in the shared sde_trigger definitions package.
REQ-039 The per-channel datapath SHALL be a sub-module deconvolve_chan, instantiated N_CHAN times; coefficient control, priming and OUT_VALID stay in the top level.

Verification
REQ-040 Test: FD=0, FN=1.0, baseline 0, constant input 100 -> output 100 after 5 EN strobes with OUT_VALID asserted.
REQ-041 Test: FD=0.5 (32/64), FN=2.0, step from 0 to 200 -> outputs 400, 200, 200, ...
REQ-042 Test: ADC_IN=50 with baseline integer part 80 -> L=80, and with FD=0 the output is 80.
REQ-043 Test: input 4095 with FN=3.0 -> output 4095, SAT_CNT increments on each sample; a bypassed channel outputs 4095 with its counter unchanged.
REQ-044 Test: COEF_LOAD on the same cycle as an EN strobe -> the new coefficient takes effect exactly one EN strobe later, on all channels simultaneously.
REQ-045 Test: RST asserted mid-stream -> ADC_OUT=0 and OUT_VALID=0 immediately; valid returns only after 5 new EN strobes.
